// File: rtl/alu_capture_pkg.sv
// rtl/alu_capture_pkg.sv - shared types for the ALU result capture stage; entry layout follows ALU_CAPTURE_ZERO_FLAG_EN
package alu_capture_pkg;

  localparam int ALU_W = 4;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WRITE
  } state_t;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             carry;
    logic [SEL_W-1:0] tag;
`ifdef ALU_CAPTURE_ZERO_FLAG_EN
    logic             zero;
`endif
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/alu_result_capture_if.sv
// rtl/alu_result_capture_if.sv - drain-side handshake bundle; out_zero present under ALU_CAPTURE_ZERO_FLAG_EN
interface alu_result_capture_if;
  import alu_capture_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [ALU_W-1:0] out_data;
  logic             out_carry;
  logic [SEL_W-1:0] out_select;
`ifdef ALU_CAPTURE_ZERO_FLAG_EN
  logic             out_zero;
`endif

  modport master (
    output out_valid, out_data, out_carry, out_select,
`ifdef ALU_CAPTURE_ZERO_FLAG_EN
    output out_zero,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_carry, out_select,
`ifdef ALU_CAPTURE_ZERO_FLAG_EN
    input  out_zero,
`endif
    output out_ready
  );

endinterface

// File: rtl/alu_capture_fifo.sv
// rtl/alu_capture_fifo.sv - power-of-two FIFO with occupancy count and zeroed head when empty
module alu_capture_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A pop on the same edge frees the slot a full-FIFO push needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally at DEPTH; count only moves when exactly one side acts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; an empty FIFO masks whatever it holds.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_result_capture.sv
// rtl/alu_result_capture.sv - waits for the ALU to settle, then queues result/carry/tag; ALU_CAPTURE_ZERO_FLAG_EN adds out_zero
module alu_result_capture
  import alu_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DEPTH         = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [SEL_W-1:0]           select_in,
  input  logic [ALU_W-1:0]           alu_result,
  input  logic                       alu_carry,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  alu_result_capture_if.master       out_if
);

  state_t           state, state_next;
  logic [3:0]       settle_cnt, settle_cnt_next;
  logic [SEL_W-1:0] tag_q, tag_next;
  logic             push, pop, push_ok, stall, fifo_empty;
  entry_t           wentry, rentry;

  assign pop     = out_if.out_valid && out_if.out_ready;
  assign push_ok = !full || pop;
  assign busy    = (state != IDLE);

  // The result is sampled live in WRITE so a stalled push keeps tracking the ALU.
  assign wentry.result = alu_result;
  assign wentry.carry  = alu_carry;
  assign wentry.tag    = tag_q;
`ifdef ALU_CAPTURE_ZERO_FLAG_EN
  assign wentry.zero   = (alu_result == '0);
`endif

  // State, settle counter, tag latch and sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      tag_q      <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
      tag_q      <= tag_next;
      if (stall) overflow <= 1'b1;
    end
  end

  // Next-state logic: starts outside IDLE are dropped, WRITE holds until a slot is free.
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    tag_next        = tag_q;
    push            = 1'b0;
    stall           = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          tag_next        = select_in;
          settle_cnt_next = 4'(SETTLE_CYCLES - 1);
          state_next      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) state_next = WRITE;
        else                  settle_cnt_next = settle_cnt - 4'd1;
      end
      WRITE: begin
        if (push_ok) begin
          push       = 1'b1;
          state_next = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  alu_capture_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (rentry),
    .count (count),
    .full  (full),
    .empty (fifo_empty)
  );

  assign out_if.out_valid  = !fifo_empty;
  assign out_if.out_data   = rentry.result;
  assign out_if.out_carry  = rentry.carry;
  assign out_if.out_select = rentry.tag;
`ifdef ALU_CAPTURE_ZERO_FLAG_EN
  assign out_if.out_zero   = rentry.zero;
`endif

endmodule

// File: tb/tb_alu_result_capture.sv
// tb/tb_alu_result_capture.sv - directed bench for alu_result_capture; zero-flag checks under ALU_CAPTURE_ZERO_FLAG_EN
module tb_alu_result_capture;

  localparam int SETTLE = 4;
  localparam int DEPTH  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] select_in = '0;
  logic [3:0] alu_result = '0;
  logic       alu_carry = 1'b0;
  logic       busy;
  logic [2:0] count;
  logic       full;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_capture_if out_if ();

  alu_result_capture #(
    .SETTLE_CYCLES (SETTLE),
    .DEPTH         (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .select_in  (select_in),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .busy       (busy),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .out_if     (out_if.master)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] res;
    logic       carry;
    logic [3:0] exp_data;
    logic       exp_carry;
    logic [2:0] exp_sel;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},       32'(busy), 0);
    check({tag, " out_valid"},  32'(out_if.out_valid), 0);
    check({tag, " out_data"},   32'(out_if.out_data), 0);
    check({tag, " out_carry"},  32'(out_if.out_carry), 0);
    check({tag, " out_select"}, 32'(out_if.out_select), 0);
    check({tag, " count"},      32'(count), 0);
    check({tag, " full"},       32'(full), 0);
    check({tag, " overflow"},   32'(overflow), 0);
`ifdef ALU_CAPTURE_ZERO_FLAG_EN
    check({tag, " out_zero"},   32'(out_if.out_zero), 0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 64) begin
      tick();
      n++;
    end
    check({tag, " idle_bound"}, 32'(busy), 0);
  endtask

  task automatic capture(input logic [2:0] sel, input logic [3:0] res, input logic c, input string tag);
    select_in  = sel;
    alu_result = res;
    alu_carry  = c;
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(tag);
  endtask

  // Exact latency: busy for SETTLE+1 samples, entry visible right after.
  task automatic capture_timed(input vec_t v, input string tag);
    select_in  = v.sel;
    alu_result = v.res;
    alu_carry  = v.carry;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < SETTLE + 1; i++) begin
      check($sformatf("%s busy_c%0d", tag, i), 32'(busy), 1);
      check($sformatf("%s early_valid_c%0d", tag, i), 32'(out_if.out_valid), 0);
      tick();
    end
    check({tag, " busy_done"},  32'(busy), 0);
    check({tag, " out_valid"},  32'(out_if.out_valid), 1);
    check({tag, " out_data"},   32'(out_if.out_data), 32'(v.exp_data));
    check({tag, " out_carry"},  32'(out_if.out_carry), 32'(v.exp_carry));
    check({tag, " out_select"}, 32'(out_if.out_select), 32'(v.exp_sel));
    check({tag, " count"},      32'(count), 1);
  endtask

  task automatic pop_one();
    out_if.out_ready = 1'b1;
    tick();
    out_if.out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{sel: 3'b010, res: 4'h8, carry: 1'b0, exp_data: 4'h8, exp_carry: 1'b0, exp_sel: 3'd2};
    vecs[1] = '{sel: 3'b111, res: 4'hF, carry: 1'b1, exp_data: 4'hF, exp_carry: 1'b1, exp_sel: 3'd7};
    vecs[2] = '{sel: 3'b000, res: 4'h0, carry: 1'b1, exp_data: 4'h0, exp_carry: 1'b1, exp_sel: 3'd0};
    vecs[3] = '{sel: 3'b101, res: 4'hA, carry: 1'b0, exp_data: 4'hA, exp_carry: 1'b0, exp_sel: 3'd5};

    out_if.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    tick();
    check_reset_outputs("post_reset");

    // Single captures from an empty FIFO, each drained before the next.
    for (int i = 0; i < 4; i++) begin
      capture_timed(vecs[i], $sformatf("vec%0d", i));
      pop_one();
      check($sformatf("vec%0d drained_valid", i), 32'(out_if.out_valid), 0);
      check($sformatf("vec%0d drained_count", i), 32'(count), 0);
    end

    // Fill to full, stall a fifth capture, then release with a simultaneous pop/push.
    for (int i = 1; i <= 4; i++) capture(3'(i), 4'(i), 1'b0, $sformatf("fill%0d", i));
    check("fill count", 32'(count), 4);
    check("fill full", 32'(full), 1);
    check("fill overflow", 32'(overflow), 0);
    select_in  = 3'd5;
    alu_result = 4'd5;
    alu_carry  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (SETTLE + 1) tick();
    check("stall busy", 32'(busy), 1);
    check("stall overflow", 32'(overflow), 1);
    check("stall count", 32'(count), 4);
    check("stall head", 32'(out_if.out_data), 1);
    out_if.out_ready = 1'b1;
    tick();
    check("swap count", 32'(count), 4);
    check("swap busy", 32'(busy), 0);
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("drain%0d data", i), 32'(out_if.out_data), 32'(i));
      check($sformatf("drain%0d sel", i), 32'(out_if.out_select), 32'(i));
      check($sformatf("drain%0d carry", i), 32'(out_if.out_carry), (i == 5) ? 1 : 0);
      tick();
    end
    out_if.out_ready = 1'b0;
    check("drain empty", 32'(out_if.out_valid), 0);
    check("overflow sticky", 32'(overflow), 1);
    do_reset();
    check("overflow cleared", 32'(overflow), 0);

    // Continuous drain across more than two pointer wraps.
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      capture(3'(i % 8), 4'(i + 3), 1'(i % 2), $sformatf("wrap%0d", i));
      check($sformatf("wrap%0d count", i), 32'(count), 1);
      check($sformatf("wrap%0d data", i), 32'(out_if.out_data), 32'(i + 3));
      check($sformatf("wrap%0d sel", i), 32'(out_if.out_select), 32'(i % 8));
      check($sformatf("wrap%0d carry", i), 32'(out_if.out_carry), 32'(i % 2));
    end
    tick();
    out_if.out_ready = 1'b0;
    check("wrap empty", 32'(count), 0);

    // A second start during SETTLE must not produce an entry.
    select_in  = 3'd6;
    alu_result = 4'hC;
    alu_carry  = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("dup");
    repeat (10) tick();
    check("dup count", 32'(count), 1);
    check("dup data", 32'(out_if.out_data), 32'hC);
    check("dup busy", 32'(busy), 0);

    // Asynchronous reset in SETTLE with two entries queued.
    capture(3'd1, 4'h7, 1'b1, "pre_abort");
    check("pre_abort count", 32'(count), 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort in_settle", 32'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clock);
    reset = 1'b1;
    tick();
    capture_timed(vecs[0], "recover");
    pop_one();
    check("recover drained", 32'(count), 0);

`ifdef ALU_CAPTURE_ZERO_FLAG_EN
    capture(3'd3, 4'h0, 1'b0, "zero_a");
    capture(3'd4, 4'hF, 1'b0, "zero_b");
    check("zero head0", 32'(out_if.out_zero), 1);
    pop_one();
    check("zero head1", 32'(out_if.out_zero), 0);
    pop_one();
    check("zero empty", 32'(out_if.out_zero), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_capture.md
# alu_result_capture

Downstream capture stage for the 4-bit gate-level ALU. On a `start` strobe it waits a fixed number of clock cycles for the ALU's slow combinational result to settle, then samples `RegOut`/`Carryout` together with the operation tag into a small FIFO. A valid/ready handshake drains the FIFO to the consumer. The block owns all registering of ALU results; the ALU itself stays purely combinational.

## Interface
- `SETTLE_CYCLES`, 4: cycles between accepting `start` and entering WRITE; legal range 1..15.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `clock` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `start` input 1: operands and Select are applied to the ALU this cycle; begin a capture.
- `select_in` input 3: ALU Select value, latched as the entry tag on the accepted `start`.
- `alu_result` input 4: ALU `RegOut`.
- `alu_carry` input 1: ALU `Carryout`.
- `busy` output 1: high when the state is not IDLE; `start` is ignored while high.
- `out_valid` output 1: FIFO not empty.
- `out_ready` input 1: consumer accepts the head entry.
- `out_data` output 4: head result; 0 when empty.
- `out_carry` output 1: head carry; 0 when empty.
- `out_select` output 3: head tag; 0 when empty.
- `count` output $clog2(DEPTH+1): current occupancy.
- `full` output 1: count == DEPTH.
- `overflow` output 1: sticky; set when WRITE stalls on full; cleared only by reset.

## Operation
- FSM states: IDLE, SETTLE, WRITE.
- IDLE: if `start`, latch `select_in`, load the counter with SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE: decrement the counter each cycle. When the counter is 0, go to WRITE.
- WRITE: push {alu_result, alu_carry, tag} when `push_ok` is true, then go to IDLE. Otherwise hold in WRITE, re-sampling the inputs every cycle until the push succeeds, and set `overflow`.
- `push_ok` = !full || (out_valid && out_ready). A simultaneous pop frees a slot in the same cycle.
- Pop: on a rising edge where out_valid && out_ready. Ready is ignored when the FIFO is empty.
- Simultaneous push and pop: `count` is unchanged and pointers advance independently.
- Pointers wrap modulo DEPTH. `count` saturates at DEPTH and never wraps.
- `start` arriving in SETTLE or WRITE is dropped. There is no queueing of starts.

## Timing
- Reset values: state IDLE, counter 0, pointers 0, `count` 0, `busy` 0, `out_valid` 0, `out_data`/`out_carry`/`out_select` 0, `full` 0, `overflow` 0.
- A reset asserted mid-capture or with a non-empty FIFO aborts immediately. All contents are lost, and outputs take their reset values asynchronously.
- If `start` is accepted at edge k:
  - WRITE is entered at edge k+SETTLE_CYCLES.
  - The push occurs at edge k+SETTLE_CYCLES+1 (absent stall).
  - `out_valid` rises after that edge.
- Latency from `start` to visible entry: SETTLE_CYCLES+1 cycles. `busy` is high for exactly SETTLE_CYCLES+1 cycles without stall.
- Back-to-back captures: the next `start` can be accepted in the cycle after return to IDLE.
- Head outputs are registered/combinational from the FIFO read pointer. There are no bubbles between consecutive pops.

## Configuration
- `ALU_CAPTURE_ZERO_FLAG_EN` defined:
  - Each entry also stores zero = (alu_result == 0).
  - Adds an output port `out_zero` (1 bit, 0 when empty or in reset).
- Not defined: the port and storage bit are absent. All other behaviour is identical.

## Structure
- Package `alu_capture_pkg`:
  - state enum {IDLE, SETTLE, WRITE}
  - entry struct {result[3:0], carry, tag[2:0], optional zero}
  - localparam `ALU_W = 4`, `SEL_W = 3`
- Sub-module `alu_capture_fifo`:
  - Parameterized DEPTH, entry-width storage.
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - The top-level holds the FSM, settle counter and overflow flag.

## Test plan
- Reset, then `start` with select_in=3'b010, alu_result=4'h8, carry=0, SETTLE_CYCLES=4 -> out_valid rises 5 cycles later with out_data=8, out_select=2; busy high for 5 cycles.
- With out_ready=0, perform four captures (values 1, 2, 3, 4), then a fifth with value 5 -> full=1, busy stays high, overflow=1. Raise out_ready -> pops 1 and pushes 5 in the same cycle; count stays 4, then drains 2, 3, 4, 5 in order.
- `start` pulsed again during SETTLE -> ignored; exactly one entry is produced.
- Hold out_ready=1 across pushes/pops over ≥2 pointer wraps (10 captures) -> all 10 results are delivered in order; count never exceeds 1.
- Assert reset during SETTLE with 2 entries queued -> all outputs read 0 immediately. After release, a new capture behaves as from cold reset.
- Build with `ALU_CAPTURE_ZERO_FLAG_EN` and capture alu_result=0, then 4'hF -> out_zero reads 1, then 0.
